ps2_multi_param_entry: RTL and testbench

//  Parametrised PS/2 numeric entry controller for the effect chain. Owner selects a channel
//  (volume/pitch/distortion/...); user types up to DIGITS decimal digits on a PS/2 keyboard,

---
 rtl/ps2_multi_param_entry_if.sv | 28 ++
 rtl/ps2_multi_param_entry.sv | 183 ++++++++++++++++++
 tb/tb_ps2_multi_param_entry.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_multi_param_entry_if.sv
// Bus bundle between the PS/2 byte receiver / channel owner and the numeric entry controller.
// master drives keystrokes and channel requests; slave is the entry controller.
interface ps2_multi_param_entry_if #(
    parameter int NUM_CH = 3,
    parameter int VAL_W  = 7
);
    logic [7:0]              ps2_key_data;
    logic                    ps2_key_pressed;
    logic [NUM_CH-1:0]       ch_enable;
    logic [NUM_CH-1:0]       ch_request;
    logic                    busy;
    logic [2:0]              active_ch;
    logic [2:0]              digit_count;
    logic [13:0]             entry_value;
    logic                    commit_pulse;
    logic                    abort_pulse;
    logic [NUM_CH*VAL_W-1:0] ch_values;

    modport master (
        output ps2_key_data, ps2_key_pressed, ch_enable, ch_request,
        input  busy, active_ch, digit_count, entry_value, commit_pulse, abort_pulse, ch_values
    );

    modport slave (
        input  ps2_key_data, ps2_key_pressed, ch_enable, ch_request,
        output busy, active_ch, digit_count, entry_value, commit_pulse, abort_pulse, ch_values
    );
endinterface

// File: rtl/ps2_multi_param_entry.sv
// PS/2 decimal entry controller: per-channel values typed, edited, clamped and committed.
// Optional idle-keystroke timeout enabled by defining PS2_ENTRY_TIMEOUT_EN.
module ps2_multi_param_entry #(
    parameter int          NUM_CH      = 3,
    parameter int          DIGITS      = 3,
    parameter int          VAL_W       = 7,
    parameter int          MAX_VAL     = 100,
    parameter int unsigned TIMEOUT_CYC = 50_000_000
) (
    input  logic                   Clock,
    input  logic                   Resetn,
    ps2_multi_param_entry_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE, S_ARM, S_ENTRY, S_SKIP_BREAK, S_COMMIT, S_ABORT
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [2:0]       r_active_ch;
    logic [2:0]       r_digit_count;
    logic [13:0]      r_entry_value;
    logic [VAL_W-1:0] r_ch_values [NUM_CH];

    logic             w_is_digit;
    logic [3:0]       w_digit;
    logic             w_req_any;
    logic [2:0]       w_req_idx;
    logic             w_en_active;
    logic             w_latch;
    logic             w_push;
    logic             w_pop;
    logic             w_timeout;
    logic [VAL_W-1:0] w_clamped;

    always_comb begin
        w_is_digit = 1'b1;
        w_digit    = '0;
        case (bus.ps2_key_data)
            8'h45:   w_digit = 4'd0;
            8'h16:   w_digit = 4'd1;
            8'h1E:   w_digit = 4'd2;
            8'h26:   w_digit = 4'd3;
            8'h25:   w_digit = 4'd4;
            8'h2E:   w_digit = 4'd5;
            8'h36:   w_digit = 4'd6;
            8'h3D:   w_digit = 4'd7;
            8'h3E:   w_digit = 4'd8;
            8'h46:   w_digit = 4'd9;
            default: w_is_digit = 1'b0;
        endcase
    end

    // Lowest enabled requester wins; also look up the enable of the channel being edited.
    always_comb begin
        w_req_any   = 1'b0;
        w_req_idx   = '0;
        w_en_active = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (bus.ch_request[i] && bus.ch_enable[i] && !w_req_any) begin
                w_req_any = 1'b1;
                w_req_idx = 3'(i);
            end
            if (r_active_ch == 3'(i))
                w_en_active = bus.ch_enable[i];
        end
    end

`ifdef PS2_ENTRY_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TO_W-1:0] r_idle_cnt;
    logic            w_waiting;

    assign w_waiting = (r_state == S_ENTRY) || (r_state == S_SKIP_BREAK);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            r_idle_cnt <= '0;
        else if (r_state == S_ARM || (w_waiting && bus.ps2_key_pressed))
            r_idle_cnt <= '0;
        else if (w_waiting)
            r_idle_cnt <= r_idle_cnt + TO_W'(1);
    end

    assign w_timeout = w_waiting && !bus.ps2_key_pressed &&
                       (r_idle_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // Loss of the edited channel's enable outranks any keystroke in the same cycle.
    always_comb begin
        w_next  = r_state;
        w_latch = 1'b0;
        w_push  = 1'b0;
        w_pop   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_req_any) begin
                    w_next  = S_ARM;
                    w_latch = 1'b1;
                end
            end
            S_ARM:
                w_next = w_en_active ? S_ENTRY : S_ABORT;
            S_ENTRY: begin
                if (!w_en_active || w_timeout)
                    w_next = S_ABORT;
                else if (bus.ps2_key_pressed) begin
                    if (bus.ps2_key_data == 8'hF0)
                        w_next = S_SKIP_BREAK;
                    else if (w_is_digit)
                        w_push = (r_digit_count < 3'(DIGITS));
                    else if (bus.ps2_key_data == 8'h66)
                        w_pop = (r_digit_count != '0);
                    else if (bus.ps2_key_data == 8'h5A)
                        w_next = (r_digit_count != '0) ? S_COMMIT : S_ABORT;
                    else if (bus.ps2_key_data == 8'h76)
                        w_next = S_ABORT;
                end
            end
            S_SKIP_BREAK: begin
                if (!w_en_active || w_timeout)
                    w_next = S_ABORT;
                else if (bus.ps2_key_pressed)
                    w_next = S_ENTRY;
            end
            S_COMMIT, S_ABORT:
                w_next = S_IDLE;
            default:
                w_next = S_IDLE;
        endcase
    end

    assign w_clamped = (r_entry_value > 14'(MAX_VAL)) ? VAL_W'(MAX_VAL)
                                                      : r_entry_value[VAL_W-1:0];

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_active_ch   <= '0;
            r_digit_count <= '0;
            r_entry_value <= '0;
            for (int unsigned i = 0; i < NUM_CH; i++)
                r_ch_values[i] <= '0;
        end else begin
            if (w_latch) begin
                r_active_ch   <= w_req_idx;
                r_digit_count <= '0;
                r_entry_value <= '0;
            end else if (w_push) begin
                r_entry_value <= r_entry_value * 14'd10 + 14'(w_digit);
                r_digit_count <= r_digit_count + 3'd1;
            end else if (w_pop) begin
                r_entry_value <= r_entry_value / 14'd10;
                r_digit_count <= r_digit_count - 3'd1;
            end
            if (r_state == S_COMMIT) begin
                for (int unsigned i = 0; i < NUM_CH; i++)
                    if (r_active_ch == 3'(i))
                        r_ch_values[i] <= w_clamped;
            end
        end
    end

    always_comb begin
        bus.busy         = (r_state != S_IDLE);
        bus.commit_pulse = (r_state == S_COMMIT);
        bus.abort_pulse  = (r_state == S_ABORT);
        bus.active_ch    = r_active_ch;
        bus.digit_count  = r_digit_count;
        bus.entry_value  = r_entry_value;
        bus.ch_values    = '0;
        for (int unsigned i = 0; i < NUM_CH; i++)
            bus.ch_values[i*VAL_W +: VAL_W] = r_ch_values[i];
    end
endmodule

// File: tb/tb_ps2_multi_param_entry.sv
// Scoreboard bench for ps2_multi_param_entry: directed keystroke sequences, pulses checked by a monitor.
// Timeout scenario runs only when PS2_ENTRY_TIMEOUT_EN is defined.
module tb_ps2_multi_param_entry;
    localparam int NUM_CH  = 3;
    localparam int DIGITS  = 3;
    localparam int VAL_W   = 7;
    localparam int MAX_VAL = 100;
    localparam int VW      = NUM_CH * VAL_W;

    logic Clock;
    logic Resetn;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        bit          is_commit;
        int          ch;
        int          ev;
        logic [VW-1:0] vals;
    } exp_t;

    exp_t          sbq[$];
    logic [VW-1:0] exp_vals = '0;

    ps2_multi_param_entry_if #(.NUM_CH(NUM_CH), .VAL_W(VAL_W)) bus ();

    ps2_multi_param_entry #(
        .NUM_CH(NUM_CH), .DIGITS(DIGITS), .VAL_W(VAL_W),
        .MAX_VAL(MAX_VAL), .TIMEOUT_CYC(100)
    ) dut (
        .Clock(Clock),
        .Resetn(Resetn),
        .bus(bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish, required finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic expect_commit(input int ch, input int ev, input int stored);
        exp_t e;
        exp_vals[ch*VAL_W +: VAL_W] = VAL_W'(stored);
        e.is_commit = 1'b1; e.ch = ch; e.ev = ev; e.vals = exp_vals;
        sbq.push_back(e);
    endtask

    task automatic expect_abort();
        exp_t e;
        e.is_commit = 1'b0; e.ch = 0; e.ev = 0; e.vals = exp_vals;
        sbq.push_back(e);
    endtask

    task automatic request(input logic [2:0] r);
        @(posedge Clock); #1 bus.ch_request = r;
        @(posedge Clock); #1 bus.ch_request = '0;
    endtask

    task automatic key(input logic [7:0] k);
        @(posedge Clock); #1 bus.ps2_key_data = k; bus.ps2_key_pressed = 1'b1;
        @(posedge Clock); #1 bus.ps2_key_pressed = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        do begin
            @(negedge Clock);
            n++;
        end while (bus.busy && n < 40);
        chk({name, "_idle"}, 64'(bus.busy), 64'd0);
    endtask

    // Monitor: every pulse pops one expectation; stored values are checked the following cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge Clock);
            if (Resetn && (bus.commit_pulse || bus.abort_pulse)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse commit=%0b abort=%0b required none",
                             bus.commit_pulse, bus.abort_pulse);
                end else begin
                    e = sbq.pop_front();
                    chk("pulse_is_commit", 64'(bus.commit_pulse), 64'(e.is_commit));
                    chk("pulse_is_abort", 64'(bus.abort_pulse), 64'(!e.is_commit));
                    if (e.is_commit) begin
                        chk("commit_ch", 64'(bus.active_ch), 64'(e.ch));
                        chk("commit_entry_value", 64'(bus.entry_value), 64'(e.ev));
                    end
                    @(negedge Clock);
                    chk("stored_ch_values", 64'(bus.ch_values), 64'(e.vals));
                    chk("busy_after_pulse", 64'(bus.busy), 64'd0);
                end
            end
        end
    end

    initial begin
`ifdef PS2_ENTRY_TIMEOUT_EN
        int cyc;
`endif
        Resetn              = 1'b0;
        bus.ps2_key_data    = '0;
        bus.ps2_key_pressed = 1'b0;
        bus.ch_enable       = '0;
        bus.ch_request      = '0;
        repeat (3) @(negedge Clock);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_active_ch", 64'(bus.active_ch), 64'd0);
        chk("rst_digit_count", 64'(bus.digit_count), 64'd0);
        chk("rst_entry_value", 64'(bus.entry_value), 64'd0);
        chk("rst_ch_values", 64'(bus.ch_values), 64'd0);
        chk("rst_pulses", 64'({bus.commit_pulse, bus.abort_pulse}), 64'd0);
        Resetn = 1'b1;

        // 1: ch0 = 25
        bus.ch_enable = 3'b001;
        request(3'b001);
        expect_commit(0, 25, 25);
        key(8'h1E); key(8'h2E); key(8'h5A);
        wait_idle("t1");

        // 2: ch1 = 100, then 399 clamps to 100
        bus.ch_enable = 3'b011;
        request(3'b010);
        expect_commit(1, 100, 100);
        key(8'h16); key(8'h45); key(8'h45); key(8'h5A);
        wait_idle("t2a");
        request(3'b010);
        key(8'h26); key(8'h46); key(8'h46);
        @(negedge Clock);
        chk("t2_entry_value_399", 64'(bus.entry_value), 64'd399);
        chk("t2_digit_count", 64'(bus.digit_count), 64'd3);
        expect_commit(1, 399, 100);
        key(8'h5A);
        wait_idle("t2b");

        // 3: break code skips next byte, backspace edits -> 13 on ch2
        bus.ch_enable = 3'b111;
        request(3'b100);
        expect_commit(2, 13, 13);
        key(8'h16); key(8'hF0); key(8'h16); key(8'h1E); key(8'h66); key(8'h26); key(8'h5A);
        wait_idle("t3");

        // 4: fourth digit ignored; 123 clamps to 100; Enter with no digits aborts
        request(3'b001);
        key(8'h16); key(8'h1E); key(8'h26); key(8'h25);
        @(negedge Clock);
        chk("t4_digit_count_cap", 64'(bus.digit_count), 64'd3);
        chk("t4_entry_value", 64'(bus.entry_value), 64'd123);
        expect_commit(0, 123, 100);
        key(8'h5A);
        wait_idle("t4a");
        request(3'b001);
        expect_abort();
        key(8'h5A);
        wait_idle("t4b");

        // 5: lowest requester wins, no pre-emption, enable drop beats a same-cycle Enter
        request(3'b110);
        @(negedge Clock);
        chk("t5_active_ch", 64'(bus.active_ch), 64'd1);
        request(3'b001);
        @(negedge Clock);
        chk("t5_no_preempt", 64'(bus.active_ch), 64'd1);
        key(8'h16);
        expect_abort();
        @(posedge Clock); #1 bus.ch_enable = 3'b101; bus.ps2_key_data = 8'h5A; bus.ps2_key_pressed = 1'b1;
        @(posedge Clock); #1 bus.ps2_key_pressed = 1'b0;
        wait_idle("t5");
        bus.ch_enable = 3'b111;

        // Esc aborts; extended prefix ignored
        request(3'b100);
        key(8'h1E); key(8'hE0);
        @(negedge Clock);
        chk("esc_digit_count", 64'(bus.digit_count), 64'd1);
        expect_abort();
        key(8'h76);
        wait_idle("esc");

`ifdef PS2_ENTRY_TIMEOUT_EN
        // 6: abort 100 cycles after the last accepted keystroke
        request(3'b001);
        expect_abort();
        key(8'h16);
        cyc = 0;
        do begin
            @(negedge Clock);
            cyc++;
        end while (!bus.abort_pulse && cyc < 300);
        chk("timeout_cycles", 64'(cyc), 64'd100);
        wait_idle("t6");
`endif

        // Reset mid-entry clears everything immediately
        request(3'b010);
        key(8'h1E);
        @(posedge Clock); #3 Resetn = 1'b0;
        #1;
        exp_vals = '0;
        chk("midrst_busy", 64'(bus.busy), 64'd0);
        chk("midrst_ch_values", 64'(bus.ch_values), 64'd0);
        chk("midrst_digit_count", 64'(bus.digit_count), 64'd0);
        @(negedge Clock); Resetn = 1'b1;
        repeat (3) @(negedge Clock);
        chk("postrst_busy", 64'(bus.busy), 64'd0);

        repeat (3) @(negedge Clock);
        chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
